// File: rtl/comparador_serial.sv
// Bit-serial magnitude comparator: walks the latched operands one bit pair per
// cycle, MSB-first (optional early exit) or LSB-first (last difference wins).
module comparador_serial #(
   parameter int N          = 8,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       dir,
   input  logic [N-1:0]               wordA,
   input  logic [N-1:0]               wordB,
   output logic                       busy,
   output logic                       done,
   output logic                       gt,
   output logic                       eq,
   output logic                       lt,
   output logic [$clog2(N+1)-1:0]     ciclos
);

   // state   | meaning
   // S_IDLE  | waiting for start; results of the last run held
   // S_RUN   | one bit pair examined per cycle
   // S_DONE  | result valid, done pulsed for exactly one cycle
   localparam int CW = $clog2(N+1);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t          state_q;
   logic [N-1:0]    a_q, b_q;
   logic            dir_q;
   logic [IW-1:0]   idx_q;
   logic            diff_q;
   logic [CW-1:0]   ciclos_q;
   logic            busy_q, done_q, gt_q, eq_q, lt_q;

   logic            a_bit, b_bit, bit_diff, first_hit, early, last_bit;
   logic [CW-1:0]   ciclos_d;
   logic [IW-1:0]   idx_d;

   always_comb begin
      a_bit     = a_q[idx_q];
      b_bit     = b_q[idx_q];
      bit_diff  = a_bit ^ b_bit;
      first_hit = bit_diff && !diff_q && !dir_q;
      early     = first_hit && EARLY_EXIT;
      last_bit  = (ciclos_q == CW'(N-1));
      ciclos_d  = (ciclos_q == CW'(N)) ? ciclos_q : ciclos_q + CW'(1);
      idx_d     = dir_q ? idx_q + IW'(1) : idx_q - IW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         dir_q    <= 1'b0;
         idx_q    <= '0;
         diff_q   <= 1'b0;
         ciclos_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         gt_q     <= 1'b0;
         eq_q     <= 1'b0;
         lt_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q      <= wordA;
                  b_q      <= wordB;
                  dir_q    <= dir;
                  idx_q    <= dir ? '0 : IW'(N-1);
                  diff_q   <= 1'b0;
                  ciclos_q <= '0;
                  gt_q     <= 1'b0;
                  eq_q     <= 1'b0;
                  lt_q     <= 1'b0;
                  busy_q   <= 1'b1;
                  state_q  <= S_RUN;
               end
            end
            S_RUN: begin
               ciclos_q <= ciclos_d;
               idx_q    <= idx_d;
               // LSB-first keeps overwriting so the most significant difference wins
               if ((dir_q && bit_diff) || first_hit) begin
                  gt_q   <= a_bit;
                  lt_q   <= b_bit;
                  diff_q <= 1'b1;
               end
               if (early || last_bit) begin
                  eq_q    <= !(diff_q || bit_diff);
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign gt     = gt_q;
   assign eq     = eq_q;
   assign lt     = lt_q;
   assign ciclos = ciclos_q;

endmodule

// File: tb/tb_comparador_serial.sv
// Directed bench for comparador_serial: two instances (EARLY_EXIT=1 and 0) share
// the stimulus and are checked every cycle against a run-level behavioural model.
module tb_comparador_serial;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       dir = 1'b0;
   logic [7:0] wordA = '0;
   logic [7:0] wordB = '0;

   logic [1:0] busy_w, done_w, gt_w, eq_w, lt_w;
   logic [3:0] cic_w [2];

   int n_vec = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   comparador_serial #(.N(8), .EARLY_EXIT(1'b1)) u_ee1 (
      .clk(clk), .rst_n(rst_n), .start(start), .dir(dir),
      .wordA(wordA), .wordB(wordB),
      .busy(busy_w[0]), .done(done_w[0]), .gt(gt_w[0]), .eq(eq_w[0]), .lt(lt_w[0]),
      .ciclos(cic_w[0])
   );

   comparador_serial #(.N(8), .EARLY_EXIT(1'b0)) u_ee0 (
      .clk(clk), .rst_n(rst_n), .start(start), .dir(dir),
      .wordA(wordA), .wordB(wordB),
      .busy(busy_w[1]), .done(done_w[1]), .gt(gt_w[1]), .eq(eq_w[1]), .lt(lt_w[1]),
      .ciclos(cic_w[1])
   );

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Outcome of a run from plain arithmetic; latency only shrinks for an
   // MSB-first run with early exit, where it is the position of the top differing bit.
   function automatic void expect_run(input logic [7:0] a, input logic [7:0] b, input logic d,
                                      input bit ee, output int lat,
                                      output bit g, output bit e, output bit l);
      logic [7:0] x;
      x   = a ^ b;
      g   = (a > b);
      e   = (a == b);
      l   = (a < b);
      lat = 8;
      if (!d && ee && x != 8'h00) begin
         for (int i = 0; i < 8; i++)
            if (x[i]) lat = 8 - i;
      end
   endfunction

   int m_phase [2];
   int m_lat   [2];
   int m_el    [2];
   bit m_busy [2], m_done [2], m_gt [2], m_eq [2], m_lt [2];
   bit r_gt [2], r_eq [2], r_lt [2];
   int m_cic  [2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0; m_el[k] = 0; m_lat[k] = 0; m_cic[k] = 0;
            m_busy[k] = 0; m_done[k] = 0; m_gt[k] = 0; m_eq[k] = 0; m_lt[k] = 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            case (m_phase[k])
               0: begin
                  m_done[k] = 0;
                  if (start) begin
                     int lt_tmp;
                     bit g, e, l;
                     expect_run(wordA, wordB, dir, (k == 0), lt_tmp, g, e, l);
                     m_lat[k] = lt_tmp; r_gt[k] = g; r_eq[k] = e; r_lt[k] = l;
                     m_phase[k] = 1; m_el[k] = 0; m_cic[k] = 0; m_busy[k] = 1;
                     m_gt[k] = 0; m_eq[k] = 0; m_lt[k] = 0;
                  end
               end
               1: begin
                  m_el[k]++;
                  m_cic[k] = m_el[k];
                  if (m_el[k] == m_lat[k]) begin
                     m_phase[k] = 2; m_busy[k] = 0; m_done[k] = 1;
                     m_gt[k] = r_gt[k]; m_eq[k] = r_eq[k]; m_lt[k] = r_lt[k];
                  end
               end
               default: begin
                  m_phase[k] = 0; m_done[k] = 0;
               end
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("busy[%0d]", k), busy_w[k], m_busy[k]);
            chk($sformatf("done[%0d]", k), done_w[k], m_done[k]);
            chk($sformatf("ciclos[%0d]", k), cic_w[k], m_cic[k]);
            if (m_phase[k] != 1) begin
               chk($sformatf("gt[%0d]", k), gt_w[k], m_gt[k]);
               chk($sformatf("eq[%0d]", k), eq_w[k], m_eq[k]);
               chk($sformatf("lt[%0d]", k), lt_w[k], m_lt[k]);
            end
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while ((busy_w != 2'b00 || done_w != 2'b00) && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (n >= 30) chk("idle_timeout", 1, 0);
   endtask

   task automatic do_run(input logic [7:0] a, input logic [7:0] b, input logic d,
                         input int eg, input int ee_, input int el,
                         input int lat0, input int lat1, input bit disturb);
      int  j;
      bit  seen [2];
      wait_idle();
      @(negedge clk);
      wordA = a; wordB = b; dir = d; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      j = 0;
      seen[0] = 0; seen[1] = 0;
      while (1) begin
         for (int k = 0; k < 2; k++) begin
            if (!seen[k] && done_w[k]) begin
               seen[k] = 1;
               chk($sformatf("lat[%0d] %h/%h", k, a, b), j, (k == 0) ? lat0 : lat1);
               chk($sformatf("lit_gt[%0d]", k), gt_w[k], eg);
               chk($sformatf("lit_eq[%0d]", k), eq_w[k], ee_);
               chk($sformatf("lit_lt[%0d]", k), lt_w[k], el);
               chk($sformatf("lit_cic[%0d]", k), cic_w[k], (k == 0) ? lat0 : lat1);
            end
         end
         if ((seen[0] && seen[1]) || j >= 20) break;
         @(negedge clk);
         j++;
         if (disturb && j == 2) begin
            start = 1'b1; wordA = ~a; wordB = ~b; dir = ~d;
         end
         if (disturb && j == 3) start = 1'b0;
      end
      if (!(seen[0] && seen[1])) chk("done_timeout", 0, 1);
      if (disturb) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   initial begin
      int lat;
      bit g, e, l;
      int t_done [$];

      expect_run(8'h80, 8'h7F, 1'b0, 1'b1, lat, g, e, l);
      chk("model_lat_80_7f", lat, 1);
      chk("model_gt_80_7f", g, 1);
      expect_run(8'h05, 8'h09, 1'b0, 1'b1, lat, g, e, l);
      chk("model_lat_05_09", lat, 5);
      chk("model_lt_05_09", l, 1);
      expect_run(8'h01, 8'h02, 1'b1, 1'b1, lat, g, e, l);
      chk("model_lat_dir1", lat, 8);

      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_busy", busy_w[k], 0);
         chk("rst_done", done_w[k], 0);
         chk("rst_cic", cic_w[k], 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      do_run(8'h80, 8'h7F, 1'b0, 1, 0, 0, 1, 8, 1'b0);
      do_run(8'h3C, 8'h3C, 1'b0, 0, 1, 0, 8, 8, 1'b0);
      do_run(8'h00, 8'h01, 1'b0, 0, 0, 1, 8, 8, 1'b0);
      do_run(8'h01, 8'h02, 1'b1, 0, 0, 1, 8, 8, 1'b0);
      do_run(8'hF0, 8'h0F, 1'b0, 1, 0, 0, 1, 8, 1'b0);
      do_run(8'h12, 8'h10, 1'b0, 1, 0, 0, 7, 8, 1'b0);
      do_run(8'hA5, 8'h5A, 1'b1, 1, 0, 0, 8, 8, 1'b0);
      do_run(8'h0F, 8'hF0, 1'b1, 0, 0, 1, 8, 8, 1'b1);

      wait_idle();
      @(negedge clk);
      wordA = 8'hFF; wordB = 8'hFF; dir = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("midrst_busy", busy_w[k], 0);
         chk("midrst_done", done_w[k], 0);
         chk("midrst_gt", gt_w[k], 0);
         chk("midrst_eq", eq_w[k], 0);
         chk("midrst_lt", lt_w[k], 0);
         chk("midrst_cic", cic_w[k], 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      do_run(8'h05, 8'h09, 1'b0, 0, 0, 1, 5, 8, 1'b0);

      wait_idle();
      @(negedge clk);
      wordA = 8'h80; wordB = 8'h7F; dir = 1'b0; start = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (done_w[0]) t_done.push_back(c);
      end
      start = 1'b0;
      chk("b2b_pulses", (t_done.size() >= 2) ? 1 : 0, 1);
      if (t_done.size() >= 2) chk("b2b_gap", t_done[1] - t_done[0], 3);
      wait_idle();
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
